// File: rtl/wb_mailbox_if.sv
// Pipelined Wishbone request/response bundle for one wb_mailbox port.
// The initiator drives the request fields; the mailbox drives stall, ack and read data.
interface wb_mailbox_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    sel;
  logic          stall;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, rdata
  );
endinterface

// File: rtl/wb_mailbox.sv
// Pipelined Wishbone mailbox: port A pushes words into a shared FIFO, port B pops them.
// Both ports also see STATUS, CTRL (flush) and a resettable high-water mark.
module wb_mailbox #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 8
) (
  input logic         clk,
  input logic         rst,
  wb_mailbox_if.slave a,
  wb_mailbox_if.slave b
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [AW-1:0] AddrData   = AW'(0);
  localparam logic [AW-1:0] AddrStatus = AW'(1);
  localparam logic [AW-1:0] AddrCtrl   = AW'(2);
  localparam logic [AW-1:0] AddrHwm    = AW'(3);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, hwm_q, hwm_d;
  logic          a_ack_q, b_ack_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q, a_rd, b_rd;
  logic [DW-1:0] push_data, status;
  logic          full, empty, a_acc, b_acc, push, pop, flush, hwm_clr;
  logic          unused_bits;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Stall looks only at registered occupancy, so a same-cycle push never unblocks a pop.
  assign a.stall = a.stb & a.we & (a.addr == AddrData) & full;
  assign b.stall = b.stb & ~b.we & (b.addr == AddrData) & empty;

  assign a_acc = a.cyc & a.stb & ~a.stall;
  assign b_acc = b.cyc & b.stb & ~b.stall;

  assign push    = a_acc & a.we & (a.addr == AddrData);
  assign pop     = b_acc & ~b.we & (b.addr == AddrData);
  assign flush   = (a_acc & a.we & (a.addr == AddrCtrl) & a.wdata[0]) |
                   (b_acc & b.we & (b.addr == AddrCtrl) & b.wdata[0]);
  assign hwm_clr = (a_acc & a.we & (a.addr == AddrHwm)) |
                   (b_acc & b.we & (b.addr == AddrHwm));

  assign status      = {full, empty, 21'd0, 9'(count_q)};
  assign unused_bits = ^{b.sel, b.wdata[DW-1:1]};

  always_comb begin
    push_data = '0;
    for (int i = 0; i < DW / 8; i++) begin
      push_data[8*i +: 8] = a.sel[i] ? a.wdata[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    a_rd = '0;
    if (!a.we) begin
      case (a.addr)
        AddrStatus: a_rd = status;
        AddrHwm:    a_rd = DW'(hwm_q);
        default:    a_rd = '0;
      endcase
    end
  end

  always_comb begin
    b_rd = '0;
    if (!b.we) begin
      case (b.addr)
        AddrData:   b_rd = mem_q[rptr_q];
        AddrStatus: b_rd = status;
        AddrHwm:    b_rd = DW'(hwm_q);
        default:    b_rd = '0;
      endcase
    end
  end

  // Flush wins over a concurrent push; a concurrent pop has already sampled the old head.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (hwm_clr || (count_d > hwm_q)) hwm_d = count_d;
    else                              hwm_d = hwm_q;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      hwm_q     <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      hwm_q   <= hwm_d;
      a_ack_q <= a_acc;
      b_ack_q <= b_acc;
      if (a_acc) a_rdata_q <= a_rd;
      if (b_acc) b_rdata_q <= b_rd;
    end
  end

  // Dropping CYC aborts the response but not the side effect already taken.
  assign a.ack   = a_ack_q & a.cyc;
  assign b.ack   = b_ack_q & b.cyc;
  assign a.rdata = a_rdata_q;
  assign b.rdata = b_rdata_q;
endmodule

// File: tb/tb_wb_mailbox.sv
// Directed and randomized checks of wb_mailbox against a queue-based mailbox model.
module tb_wb_mailbox;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_mailbox_if #(.AW(8), .DW(32)) a_if ();
  wb_mailbox_if #(.AW(8), .DW(32)) b_if ();

  wb_mailbox #(.DEPTH(Depth), .DW(32), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a_if),
    .b   (b_if)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  int hwm = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.cyc = 0; a_if.stb = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0; a_if.sel = '0;
  endtask

  task automatic idle_b();
    b_if.cyc = 0; b_if.stb = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0; b_if.sel = '0;
  endtask

  task automatic drive_a(input logic we, input logic [7:0] addr, input logic [31:0] d,
                         input logic [3:0] sel);
    a_if.cyc = 1; a_if.stb = 1; a_if.we = we; a_if.addr = addr; a_if.wdata = d; a_if.sel = sel;
  endtask

  task automatic drive_b(input logic we, input logic [7:0] addr, input logic [31:0] d,
                         input logic [3:0] sel);
    b_if.cyc = 1; b_if.stb = 1; b_if.we = we; b_if.addr = addr; b_if.wdata = d; b_if.sel = sel;
  endtask

  // Single transaction with a bounded wait on stall; returns the acked read data.
  task automatic a_op(input logic we, input logic [7:0] addr, input logic [31:0] d,
                      input logic [3:0] sel, output logic [31:0] rd);
    int n = 0;
    drive_a(we, addr, d, sel);
    #1;
    while (a_if.stall && n < 20) begin tick(); n++; end
    check("a_op_stall", a_if.stall, 0);
    tick();
    a_if.stb = 0;
    check("a_op_ack", a_if.ack, 1);
    rd = a_if.rdata;
    idle_a();
  endtask

  task automatic b_op(input logic we, input logic [7:0] addr, input logic [31:0] d,
                      output logic [31:0] rd);
    int n = 0;
    drive_b(we, addr, d, 4'hF);
    #1;
    while (b_if.stall && n < 20) begin tick(); n++; end
    check("b_op_stall", b_if.stall, 0);
    tick();
    b_if.stb = 0;
    check("b_op_ack", b_if.ack, 1);
    rd = b_if.rdata;
    idle_b();
  endtask

  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input bit port_b, input logic [7:0] addr);
    int cnt = q.size();
    case (addr)
      8'd0:    return port_b ? q[0] : 32'h0;
      8'd1:    return ((cnt == Depth) ? 32'h8000_0000 : 32'h0) |
                      ((cnt == 0) ? 32'h4000_0000 : 32'h0) | 32'(cnt);
      8'd3:    return 32'(hwm);
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, ea, eb;
    logic        awe, bwe, astb, bstb, e_ast, e_bst, a_acc, b_acc, flush, clr;
    logic [7:0]  aaddr, baddr;
    logic [31:0] awd, bwd;
    logic [3:0]  asel;
    int          r, push_pct, pop_pct;

    idle_a(); idle_b();
    #1;
    check("rst_a_ack", a_if.ack, 0);
    check("rst_b_ack", b_if.ack, 0);
    check("rst_a_data", a_if.rdata, 0);
    check("rst_b_data", b_if.rdata, 0);
    #20 rst = 1;
    tick();

    // 1: empty status, pop stalls when empty
    b_op(0, 8'h01, 0, rd); check("t1_status", rd, 32'h4000_0000);
    drive_b(0, 8'h00, 0, 4'hF); #1;
    check("t1_pop_stall", b_if.stall, 1);
    tick(); check("t1_pop_noack", b_if.ack, 0);
    idle_b();

    // 2: two pushes, two pops, status and high-water
    a_op(1, 8'h00, 32'hABAB_ABAB, 4'hF, rd);
    a_op(1, 8'h00, 32'h1234_5678, 4'hF, rd);
    b_op(0, 8'h00, 0, rd); check("t2_pop0", rd, 32'hABAB_ABAB);
    b_op(0, 8'h00, 0, rd); check("t2_pop1", rd, 32'h1234_5678);
    b_op(0, 8'h01, 0, rd); check("t2_status", rd, 32'h4000_0000);
    b_op(0, 8'h03, 0, rd); check("t2_hwm", rd, 32'd2);

    // 3: fill, stalled push released by a pop, drain in order
    for (int i = 0; i < 16; i++) a_op(1, 8'h00, 32'(i), 4'hF, rd);
    b_op(0, 8'h01, 0, rd); check("t3_status_full", rd, 32'h8000_0010);
    drive_a(1, 8'h00, 32'hFF, 4'hF); drive_b(0, 8'h00, 0, 4'hF); #1;
    check("t3_full_stall", a_if.stall, 1);
    check("t3_pop_nostall", b_if.stall, 0);
    tick(); b_if.stb = 0;
    check("t3_pop_ack", b_if.ack, 1);
    check("t3_pop_data", b_if.rdata, 32'h0);
    check("t3_push_noack", a_if.ack, 0);
    check("t3_push_unstall", a_if.stall, 0);
    tick(); a_if.stb = 0;
    check("t3_push_ack", a_if.ack, 1);
    idle_a(); idle_b();
    for (int i = 0; i < 16; i++) begin
      b_op(0, 8'h00, 0, rd);
      check("t3_drain", rd, (i < 15) ? 32'(i + 1) : 32'hFF);
    end

    // 4: byte selects, simultaneous push and pop
    a_op(1, 8'h00, 32'hF0F0_F0F0, 4'b0101, rd);
    b_op(0, 8'h00, 0, rd); check("t4_sel", rd, 32'h00F0_00F0);
    a_op(1, 8'h00, 32'h1111_1111, 4'hF, rd);
    drive_a(1, 8'h00, 32'h2222_2222, 4'hF); drive_b(0, 8'h00, 0, 4'hF);
    tick(); a_if.stb = 0; b_if.stb = 0;
    check("t4_push_ack", a_if.ack, 1);
    check("t4_pop_ack", b_if.ack, 1);
    check("t4_pop_data", b_if.rdata, 32'h1111_1111);
    idle_a(); idle_b();
    b_op(0, 8'h01, 0, rd); check("t4_count", rd, 32'h1);
    b_op(0, 8'h00, 0, rd); check("t4_pop2", rd, 32'h2222_2222);

    // 5: flush from B overrides a concurrent push from A
    for (int i = 0; i < 3; i++) a_op(1, 8'h00, 32'hC0 + 32'(i), 4'hF, rd);
    drive_a(1, 8'h00, 32'h7777_7777, 4'hF); drive_b(1, 8'h02, 32'h1, 4'hF);
    tick(); a_if.stb = 0; b_if.stb = 0;
    check("t5_push_ack", a_if.ack, 1);
    check("t5_flush_ack", b_if.ack, 1);
    idle_a(); idle_b();
    b_op(0, 8'h01, 0, rd); check("t5_status", rd, 32'h4000_0000);
    drive_b(0, 8'h00, 0, 4'hF); #1;
    check("t5_pop_stall", b_if.stall, 1);
    idle_b();

    // 6: HWM clear, aborted pop, reset mid-burst
    a_op(1, 8'h03, 0, 4'hF, rd);
    b_op(0, 8'h03, 0, rd); check("t6_hwm_clr", rd, 32'h0);
    a_op(1, 8'h00, 32'h5, 4'hF, rd);
    b_op(0, 8'h03, 0, rd); check("t6_hwm_one", rd, 32'h1);
    drive_b(0, 8'h00, 0, 4'hF);
    tick(); b_if.stb = 0; b_if.cyc = 0; #1;
    check("t6_abort_ack", b_if.ack, 0);
    idle_b();
    b_op(0, 8'h01, 0, rd); check("t6_abort_count", rd, 32'h4000_0000);
    drive_a(1, 8'h00, 32'hA5A5_A5A5, 4'hF);
    tick(); check("t6_burst_ack", a_if.ack, 1);
    #2 rst = 0; #1;
    check("t6_rst_ack", a_if.ack, 0);
    check("t6_rst_data", a_if.rdata, 0);
    idle_a();
    #10 rst = 1;
    tick();
    b_op(0, 8'h01, 0, rd); check("t6_rst_status", rd, 32'h4000_0000);
    b_op(0, 8'h03, 0, rd); check("t6_rst_hwm", rd, 32'h0);

    // Randomized concurrent traffic against the queue model
    q.delete(); hwm = 0;
    for (int n = 0; n < 400; n++) begin
      push_pct = (n < 200) ? 75 : 25;
      pop_pct  = (n < 200) ? 30 : 75;
      r = $urandom_range(0, 99);
      astb = 1; awe = 1; aaddr = 8'h00; awd = $urandom; asel = 4'hF;
      if (r < push_pct) begin
        if ($urandom_range(0, 3) == 0) asel = 4'($urandom);
      end else if (r < push_pct + 5) begin
        astb = 0;
      end else begin
        awe = 1'($urandom); aaddr = 8'($urandom_range(0, 5));
        if (awe && aaddr == 8'h02) awd[0] = ($urandom_range(0, 3) == 0);
      end
      r = $urandom_range(0, 99);
      bstb = 1; bwe = 0; baddr = 8'h00; bwd = $urandom;
      if (r >= pop_pct && r < pop_pct + 5) begin
        bstb = 0;
      end else if (r >= pop_pct) begin
        bwe = 1'($urandom); baddr = 8'($urandom_range(0, 5));
        if (bwe && baddr == 8'h02) bwd[0] = ($urandom_range(0, 3) == 0);
      end
      a_if.cyc = 1; a_if.stb = astb; a_if.we = awe; a_if.addr = aaddr;
      a_if.wdata = awd; a_if.sel = asel;
      b_if.cyc = 1; b_if.stb = bstb; b_if.we = bwe; b_if.addr = baddr;
      b_if.wdata = bwd; b_if.sel = 4'hF;
      e_ast = astb && awe && aaddr == 8'h00 && q.size() == Depth;
      e_bst = bstb && !bwe && baddr == 8'h00 && q.size() == 0;
      #1;
      check("r_a_stall", a_if.stall, e_ast);
      check("r_b_stall", b_if.stall, e_bst);
      a_acc = astb && !e_ast;
      b_acc = bstb && !e_bst;
      ea = (a_acc && !awe) ? exp_read(0, aaddr) : 32'h0;
      eb = (b_acc && !bwe) ? exp_read(1, baddr) : 32'h0;
      tick();
      check("r_a_ack", a_if.ack, a_acc);
      check("r_b_ack", b_if.ack, b_acc);
      if (a_acc && !awe) check("r_a_data", a_if.rdata, ea);
      if (b_acc && !bwe) check("r_b_data", b_if.rdata, eb);
      if (b_acc && !bwe && baddr == 8'h00) void'(q.pop_front());
      if (a_acc && awe && aaddr == 8'h00) q.push_back(mask_word(awd, asel));
      flush = (a_acc && awe && aaddr == 8'h02 && awd[0]) ||
              (b_acc && bwe && baddr == 8'h02 && bwd[0]);
      if (flush) q.delete();
      clr = (a_acc && awe && aaddr == 8'h03) || (b_acc && bwe && baddr == 8'h03);
      if (clr || q.size() > hwm) hwm = q.size();
    end
    idle_a(); idle_b();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_mailbox.md
Name: wb_mailbox

Overview:
- Dual-port Wishbone (pipelined) responder implementing a 32-bit mailbox FIFO between two bus initiators.
- Port A is the producer: writes to DATA push words. Port B is the consumer: reads from DATA pop words.
- Both ports expose STATUS, CTRL and high-water registers.
- Sits beside memory_top on the same A/B bus pair so two masters can stream data without sharing RAM addresses.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
DW, 32, data width; fixed to 32 for byte selects
AW, 8, address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
A_CYC_I  in  1  port A cycle valid
A_STB_I  in  1  port A request strobe
A_WE_I  in  1  port A write enable
A_ADDR_I  in  AW  port A word address
A_DATA_I  in  DW  port A write data
A_SEL_I  in  4  port A byte selects
A_STALL_O  out  1  port A cannot accept this request
A_ACK_O  out  1  port A response valid
A_DATA_O  out  DW  port A read data
B_CYC_I, B_STB_I, B_WE_I, B_ADDR_I, B_DATA_I, B_SEL_I, B_STALL_O, B_ACK_O, B_DATA_O: same as port A, for port B

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers, count and high-water cleared; empty=1, full=0.
  - A/B_ACK_O=0, A/B_DATA_O=0.
  - Storage contents are don't-care.
- Register map (identical on both ports):
  - 0x00 DATA: A write = push; B read = pop. A read of DATA returns 0. B write to DATA is ignored.
  - 0x01 STATUS (RO): [31]=full, [30]=empty, [8:0]=count (zero-extended).
  - 0x02 CTRL (WO): a write with bit0=1 flushes; reads return 0.
  - 0x03 HWM: read returns the max count since the last clear; any write clears it to the current count.
  - All other addresses: reads return 0, writes ignored, still acked.
- Acceptance:
  - A request is accepted on a rising edge with CYC_I=1, STB_I=1 and STALL_O=0.
  - STB_I without CYC_I is ignored: no ack, no side effects.
- Stall (combinational; depends on registered full/empty only):
  - A_STALL_O = A_STB_I & A_WE_I & (A_ADDR_I==0) & full.
  - B_STALL_O = B_STB_I & ~B_WE_I & (B_ADDR_I==0) & empty.
  - All other requests are never stalled.
- Response:
  - ACK_O=1 exactly one cycle after acceptance, with DATA_O registered in that same cycle.
  - Back-to-back accepted requests give back-to-back acks.
  - ACK_O is forced to 0 in any cycle where CYC_I=0 (abort). The side effect of an aborted accepted request still occurs.
  - DATA_O holds its last value when ACK_O=0.
- Push:
  - Writes storage[wptr], then wptr++ mod DEPTH and count++.
  - Bytes with SEL=0 are stored as 0x00.
  - A pushed word is poppable by a pop accepted in the following cycle; there is no same-cycle bypass.
- Pop:
  - Returns storage[rptr] at ack, then rptr++ mod DEPTH and count--.
- Simultaneous events:
  - Push + pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
  - When full, the push is stalled; a concurrent pop proceeds, and the push is accepted on the next cycle.
  - When empty, the pop is stalled even if a push is accepted the same cycle.
- Flush:
  - Takes effect at the accepting edge: pointers=0, count=0.
  - Flush overrides a push accepted the same edge on the other port; the push is dropped but still acked.
  - A pop accepted the same edge returns the old head, then the flush is applied.
  - Flushes from both ports in the same cycle equal one flush.
- HWM:
  - Updated every cycle to max(HWM, next count).
  - A clear and a count increase on the same edge leave HWM = next count.
- Pointer widths are $clog2(DEPTH). count is $clog2(DEPTH)+1 bits, so count=DEPTH is representable.
- Async reset mid-transaction drops any pending ack immediately.

Test Plan:
1. Reset, then B reads 0x01 → ack next cycle, B_DATA_O=0x40000000. A pop at 0x00 gives B_STALL_O=1 while strobed.
2. A pushes 0xABABABAB, 0x12345678; B pops twice → B_DATA_O=0xABABABAB then 0x12345678. STATUS then reads 0x40000000 and HWM reads 2.
3. A pushes 16 words 0x00..0x0F → STATUS=0x80000010. The 17th push (0xFF) stalls. B pops once → 0x00, then 0xFF is accepted the next cycle. After 16 more pops the data sequence is 0x01..0x0F, 0xFF.
4. A writes 0xF0F0F0F0 with SEL=4'b0101 → popped value is 0x00F000F0. A pushes, and B pops in the same cycle as A's second push → pop returns the first word and count stays 1.
5. A pushes 3 words, then B writes CTRL=1 in the same cycle as A pushes 0x77777777 → both acked, STATUS=0x40000000, and the next pop stalls.
6. B issues a pop, then drops CYC in the ack cycle → B_ACK_O=0 and count is still decremented. rst asserted mid-burst → ACKs drop to 0 immediately and STATUS reads 0x40000000 after release.
